// File: rtl/mips_fetch_btb.sv
// MIPS instruction fetch stage with a direct-mapped branch target buffer.
// Holds the PC and the IF/ID pipeline register; the BTB is trained by resolved branches from EX.
module mips_fetch_btb #(
  parameter int unsigned BTB_ENTRIES    = 8,
  parameter logic [31:0] RESET_PC       = 32'd0,
  parameter logic [31:0] EXCEPTION_ADDR = 32'd392
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exception,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] PCPlus4Reg,
  output logic [31:0] InstReg,
  output logic        FindinBTBReg,
  output logic        takenReg
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] validVec;
  logic [TAG_W-1:0]       tagArr    [BTB_ENTRIES];
  logic [31:0]            targetArr [BTB_ENTRIES];
  logic [1:0]             cntArr    [BTB_ENTRIES];

  logic [IDX_W-1:0] lkIdx;
  logic [TAG_W-1:0] lkTag;
  logic             lkHit;
  logic             lkTaken;
  logic [31:0]      pcPlus4;
  logic [31:0]      nextPC;

  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic             updHit;
  logic [1:0]       updCntNext;
  logic             unusedUpdBits;

  // Combinational lookup on the current PC; reads the pre-update array contents.
  assign lkIdx   = PC[IDX_W+1:2];
  assign lkTag   = PC[31:IDX_W+2];
  assign lkHit   = validVec[lkIdx] && (tagArr[lkIdx] == lkTag);
  assign lkTaken = lkHit && cntArr[lkIdx][1];
  assign pcPlus4 = PC + 32'd4;

  assign updIdx        = upd_pc[IDX_W+1:2];
  assign updTag        = upd_pc[31:IDX_W+2];
  assign updHit        = validVec[updIdx] && (tagArr[updIdx] == updTag);
  assign unusedUpdBits = ^upd_pc[1:0];

  always_comb begin
    nextPC = pcPlus4;
    if (exception) begin
      nextPC = EXCEPTION_ADDR;
    end else if (redirect) begin
      nextPC = redirect_pc;
    end else if (stall) begin
      nextPC = PC;
    end else if (lkTaken) begin
      nextPC = targetArr[lkIdx];
    end
  end

  // 2-bit saturating counter step for the entry being trained.
  always_comb begin
    updCntNext = cntArr[updIdx];
    if (upd_taken && (cntArr[updIdx] != 2'd3)) begin
      updCntNext = cntArr[updIdx] + 2'd1;
    end else if (!upd_taken && (cntArr[updIdx] != 2'd0)) begin
      updCntNext = cntArr[updIdx] - 2'd1;
    end
  end

  // PC and IF/ID register; a flush inserts a NOP bubble even while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC           <= RESET_PC;
      PCPlus4Reg   <= 32'd0;
      InstReg      <= 32'd0;
      FindinBTBReg <= 1'b0;
      takenReg     <= 1'b0;
    end else begin
      PC <= nextPC;
      if (exception || redirect) begin
        PCPlus4Reg   <= 32'd0;
        InstReg      <= 32'd0;
        FindinBTBReg <= 1'b0;
        takenReg     <= 1'b0;
      end else if (!stall) begin
        PCPlus4Reg   <= pcPlus4;
        InstReg      <= Instruction;
        FindinBTBReg <= lkHit;
        takenReg     <= lkTaken;
      end
    end
  end

  // BTB training: hits adjust the counter, taken misses allocate, not-taken misses are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validVec <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tagArr[i]    <= '0;
        targetArr[i] <= 32'd0;
        cntArr[i]    <= 2'd0;
      end
    end else if (upd_en) begin
      if (updHit) begin
        cntArr[updIdx] <= updCntNext;
        if (upd_taken) begin
          targetArr[updIdx] <= upd_target;
        end
      end else if (upd_taken) begin
        validVec[updIdx]  <= 1'b1;
        tagArr[updIdx]    <= updTag;
        targetArr[updIdx] <= upd_target;
        cntArr[updIdx]    <= 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_btb.sv
// Self-checking bench for mips_fetch_btb: directed scenarios plus randomized traffic
// checked against a behavioural fetch/BTB model.
module tb_mips_fetch_btb;

  localparam int unsigned N   = 8;
  localparam logic [31:0] EXC = 32'd392;

  logic        clk;
  logic        reset;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exception;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] PCPlus4Reg;
  logic [31:0] InstReg;
  logic        FindinBTBReg;
  logic        takenReg;

  int total = 0;
  int bad   = 0;

  mips_fetch_btb #(.BTB_ENTRIES(N), .RESET_PC(32'd0), .EXCEPTION_ADDR(EXC)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Instruction(Instruction),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .exception(exception),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .PCPlus4Reg(PCPlus4Reg), .InstReg(InstReg), .FindinBTBReg(FindinBTBReg), .takenReg(takenReg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: a unique, never-zero word per address.
  function automatic logic [31:0] instOf(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, ~a[15:0]};
  endfunction

  assign Instruction = instOf(PC);

  // Behavioural model: each slot remembers the full branch address it was trained with.
  logic [31:0] mPC, mP4, mInst;
  logic        mHit, mTk;
  logic        mV   [N];
  logic [31:0] mBpc [N];
  logic [31:0] mTgt [N];
  int          mCnt [N];

  logic [128:0] dutVec;
  assign dutVec = {PC, InstReg, PCPlus4Reg, FindinBTBReg, takenReg};

  function automatic logic [128:0] expVec();
    return {mPC, mInst, mP4, mHit, mTk};
  endfunction

  function automatic int idxOf(input logic [31:0] a);
    return int'((a / 4) % N);
  endfunction

  function automatic logic sameLine(input logic [31:0] a, input logic [31:0] b);
    return (a / (4 * N)) == (b / (4 * N));
  endfunction

  task automatic model_reset();
    mPC = 32'd0; mP4 = 32'd0; mInst = 32'd0; mHit = 1'b0; mTk = 1'b0;
    for (int i = 0; i < N; i++) begin
      mV[i] = 1'b0; mBpc[i] = 32'd0; mTgt[i] = 32'd0; mCnt[i] = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, and land #1 after the rising edge.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc, input logic ex,
                     input logic ue, input logic [31:0] upc, input logic [31:0] ut, input logic utk);
    int i, j;
    logic h, t;
    logic [31:0] nPC;
    stall = st; redirect = rd; redirect_pc = rpc; exception = ex;
    upd_en = ue; upd_pc = upc; upd_target = ut; upd_taken = utk;
    i = idxOf(mPC);
    h = mV[i] && sameLine(mBpc[i], mPC);
    t = h && (mCnt[i] >= 2);
    if (ex) nPC = EXC;
    else if (rd) nPC = rpc;
    else if (st) nPC = mPC;
    else if (t) nPC = mTgt[i];
    else nPC = mPC + 32'd4;
    if (ex || rd) begin
      mP4 = 32'd0; mInst = 32'd0; mHit = 1'b0; mTk = 1'b0;
    end else if (!st) begin
      mP4 = mPC + 32'd4; mInst = instOf(mPC); mHit = h; mTk = t;
    end
    if (ue) begin
      j = idxOf(upc);
      if (mV[j] && sameLine(mBpc[j], upc)) begin
        if (utk) begin
          mCnt[j] = (mCnt[j] < 3) ? mCnt[j] + 1 : 3;
          mTgt[j] = ut;
        end else begin
          mCnt[j] = (mCnt[j] > 0) ? mCnt[j] - 1 : 0;
        end
      end else if (utk) begin
        mV[j] = 1'b1; mBpc[j] = upc; mTgt[j] = ut; mCnt[j] = 2;
      end
    end
    mPC = nPC;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
  endtask

  // Pulse reset entirely between clock edges.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if (dutVec !== 129'd0) begin
      bad++; $display("FAIL reset_state got %h want 0", dutVec);
    end
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      total++;
      if ({PC, PCPlus4Reg, InstReg} !== {32'(4 * k), 32'(4 * k), instOf(32'(4 * (k - 1)))}) begin
        bad++;
        $display("FAIL seq_fetch cyc%0d got PC=%h P4=%h I=%h want PC=%h", k, PC, PCPlus4Reg, InstReg, 4 * k);
      end
    end
  endtask

  task automatic test_alloc_predict();
    do_reset();
    cyc(0, 0, 32'd0, 0, 1, 32'd8, 32'h40, 1);
    idle(1);
    total++;
    if (PC !== 32'd8) begin bad++; $display("FAIL alloc_reach8 got %h want 8", PC); end
    idle(1);
    total++;
    if ({PC, PCPlus4Reg, FindinBTBReg, takenReg} !== {32'h40, 32'd12, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL alloc_predict got PC=%h P4=%h hit=%b tk=%b want 40 c 1 1", PC, PCPlus4Reg, FindinBTBReg, takenReg);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) cyc(0, 0, 32'd0, 0, 1, 32'd8, 32'h40, 0);
    cyc(0, 1, 32'd8, 0, 0, 32'd0, 32'd0, 0);
    idle(1);
    total++;
    if ({PC, FindinBTBReg, takenReg} !== {32'd12, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sat_zero got PC=%h hit=%b tk=%b want c 1 0", PC, FindinBTBReg, takenReg);
    end
    // One taken step from a saturated zero must still predict not-taken.
    cyc(0, 1, 32'd8, 0, 1, 32'd8, 32'h40, 1);
    idle(1);
    total++;
    if ({PC, FindinBTBReg, takenReg} !== {32'd12, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sat_floor got PC=%h hit=%b tk=%b want c 1 0", PC, FindinBTBReg, takenReg);
    end
    // Lookup and training of the same slot in one cycle: lookup sees the old counter.
    cyc(0, 1, 32'd8, 0, 0, 32'd0, 32'd0, 0);
    cyc(0, 0, 32'd0, 0, 1, 32'd8, 32'h60, 1);
    total++;
    if ({PC, takenReg} !== {32'd12, 1'b0}) begin
      bad++; $display("FAIL same_cycle_upd got PC=%h tk=%b want c 0", PC, takenReg);
    end
    cyc(0, 1, 32'd8, 0, 0, 32'd0, 32'd0, 0);
    idle(1);
    total++;
    if ({PC, takenReg} !== {32'h60, 1'b1}) begin
      bad++; $display("FAIL upd_visible got PC=%h tk=%b want 60 1", PC, takenReg);
    end
  endtask

  task automatic test_priority();
    cyc(1, 1, 32'h100, 1, 0, 32'd0, 32'd0, 0);
    total++;
    if ({PC, InstReg, PCPlus4Reg, FindinBTBReg, takenReg} !== {EXC, 32'd0, 32'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL priority got PC=%h I=%h P4=%h want PC=%h bubble", PC, InstReg, PCPlus4Reg, EXC);
    end
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 32'd0, 32'd0, 0);
    idle(1);
    total++;
    if ({PC, PCPlus4Reg} !== {32'd0, 32'd0}) begin
      bad++; $display("FAIL pc_wrap got PC=%h P4=%h want 0 0", PC, PCPlus4Reg);
    end
  endtask

  task automatic test_stall();
    do_reset();
    cyc(0, 1, 32'd8, 0, 0, 32'd0, 32'd0, 0);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
      total++;
      if ({PC, PCPlus4Reg, InstReg} !== {32'd12, 32'd12, instOf(32'd8)}) begin
        bad++; $display("FAIL stall_hold cyc%0d got PC=%h P4=%h I=%h want c c %h", k, PC, PCPlus4Reg, InstReg, instOf(32'd8));
      end
    end
    idle(1);
    total++;
    if ({PC, InstReg} !== {32'd16, instOf(32'd12)}) begin
      bad++; $display("FAIL stall_resume got PC=%h I=%h want 10", PC, InstReg);
    end
  endtask

  task automatic test_async_reset();
    cyc(0, 0, 32'd0, 0, 1, 32'd8, 32'h40, 1);
    idle(1);
    reset = 1'b1;
    #1;
    total++;
    if (dutVec !== 129'd0) begin
      bad++; $display("FAIL async_reset got %h want 0", dutVec);
    end
    #1;
    reset = 1'b0;
    model_reset();
    idle(2);
    idle(1);
    total++;
    if ({PC, FindinBTBReg, takenReg} !== {32'd12, 1'b0, 1'b0}) begin
      bad++; $display("FAIL btb_cleared got PC=%h hit=%b tk=%b want c 0 0", PC, FindinBTBReg, takenReg);
    end
  endtask

  function automatic logic [31:0] pickAddr();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r == 0) return 32'hFFFF_FFFC;
    if (r == 1) return 32'hFFFF_FFF8;
    return (32'($urandom_range(0, 15)) << 2) | (($urandom_range(0, 1) == 1) ? 32'h100 : 32'h0);
  endfunction

  task automatic test_random();
    logic st, rd, ex, ue, utk;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      ex  = ($urandom_range(0, 19) == 0);
      ue  = ($urandom_range(0, 4) < 2);
      utk = ($urandom_range(0, 2) != 0);
      cyc(st, rd, pickAddr(), ex, ue, pickAddr(), pickAddr(), utk);
      total++;
      if (dutVec !== expVec()) begin
        bad++; $display("FAIL random cyc%0d got %h want %h", k, dutVec, expVec());
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; exception = 1'b0;
    upd_en = 1'b0; upd_pc = 32'd0; upd_target = 32'd0; upd_taken = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_alloc_predict();
    test_saturation();
    test_priority();
    test_stall();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_fetch_btb.md
MIPS_FETCH_BTB -- requirements
Module: mips_fetch_btb

Interface
REQ-001 Parameter BTB_ENTRIES, default 8: number of direct-mapped BTB entries, power of 2.
REQ-002 Parameter RESET_PC, default 32'd0: PC value after reset.
REQ-003 Parameter EXCEPTION_ADDR, default 32'd392: vector PC loaded on exception (512 - 120).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 PC  output  32  current fetch address driven to instruction memory.
REQ-007 Instruction  input  32  instruction word returned combinationally for PC.
REQ-008 stall  input  1  hazard stall; holds PC and IF/ID registers.
REQ-009 redirect  input  1  branch mispredict from EX; forces fetch from redirect_pc.
REQ-010 redirect_pc  input  32  corrected fetch address.
REQ-011 exception  input  1  forces fetch from EXCEPTION_ADDR.
REQ-012 upd_en  input  1  BTB update strobe for a resolved branch.
REQ-013 upd_pc  input  32  address of the resolved branch.
REQ-014 upd_target  input  32  resolved branch target.
REQ-015 upd_taken  input  1  resolved branch outcome.
REQ-016 PCPlus4Reg  output  32  IF/ID register: PC+4 of fetched instruction.
REQ-017 InstReg  output  32  IF/ID register: fetched instruction.
REQ-018 FindinBTBReg  output  1  IF/ID register: BTB hit for fetched PC.
REQ-019 takenReg  output  1  IF/ID register: predicted taken.

Function
REQ-020 The BTB index SHALL be PC[2+log2(BTB_ENTRIES)-1:2]; tag SHALL be the remaining upper PC bits; each entry SHALL hold valid, tag, 32-bit target and a 2-bit saturating counter.
REQ-021 Lookup SHALL be combinational on PC: hit = valid AND tag match; predict taken = hit AND counter >= 2.
REQ-022 Next PC priority SHALL be: exception -> EXCEPTION_ADDR; redirect -> redirect_pc; stall -> PC held; predict taken -> entry target; otherwise PC+4 (32-bit wrap, 0xFFFFFFFC+4 = 0).
REQ-023 Without stall/redirect/exception, IF/ID SHALL load {PC+4, Instruction, hit, predict taken} each cycle, giving one-cycle latency from PC to InstReg.
REQ-024 On stall without redirect/exception, IF/ID SHALL hold all values.
REQ-025 On redirect or exception, IF/ID SHALL load a bubble: InstReg = 0 (NOP), PCPlus4Reg = 0, FindinBTBReg = 0, takenReg = 0, overriding stall.
REQ-026 On upd_en with matching valid entry: counter SHALL increment (saturate at 3) if upd_taken, else decrement (saturate at 0); target SHALL be written if upd_taken.
REQ-027 On upd_en with miss and upd_taken: entry SHALL be allocated (valid = 1, new tag, target, counter = 2), replacing any occupant.
REQ-028 On upd_en with miss and not upd_taken: BTB SHALL be unchanged.
REQ-029 Update and lookup at the same index in the same cycle: lookup SHALL use pre-update contents; update SHALL be visible the next cycle.
REQ-030 upd_en SHALL be honoured regardless of stall, redirect or exception.

Reset
REQ-031 While reset is high: PC = RESET_PC, all IF/ID outputs = 0, all BTB valid bits = 0, counters = 0.
REQ-032 Reset asserted mid-operation SHALL clear state immediately, without waiting for a clock edge; the first fetch after deassertion SHALL be from RESET_PC.

Verification
REQ-033 Sequential fetch: reset, then 4 cycles with no events -> PC = 0,4,8,12; InstReg lags PC by one cycle; PCPlus4Reg = 4,8,12.
REQ-034 Allocate and predict: upd_en with upd_pc = 8, target = 0x40, taken = 1; next fetch of PC 8 -> FindinBTBReg = 1, takenReg = 1, following PC = 0x40.
REQ-035 Counter saturation: entry at counter 2, three not-taken updates -> counter 1 then 0 then 0; fetch of that PC -> hit = 1, taken = 0, next PC = PC+4.
REQ-036 Priority: stall = 1, redirect = 1 to 0x100, exception = 1 in same cycle -> next PC = 392, IF/ID bubble (InstReg = 0).
REQ-037 Stall hold: stall 3 cycles at PC 12 -> PC and IF/ID unchanged for 3 cycles, resume to 16.
REQ-038 Async reset: assert reset mid-cycle after BTB allocation -> outputs 0 before next edge; fetch of the allocated PC after release -> FindinBTBReg = 0.
